// File: rtl/dmem_pkg.sv
// dmem_pkg: FSM states, wait-count type and MMIO addresses shared by the dmem_responder slice.
package dmem_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_RD_WAIT, ST_RD_RESP, ST_WR_WAIT, ST_WR_RESP} state_t;
  typedef logic [3:0] wait_t;
  localparam logic [31:0] MMIO_CONSOLE_ADDR = 32'hFFFF_FFF0;
  localparam logic [31:0] MMIO_HALT_ADDR = 32'hFFFF_FFF4;
endpackage

// File: rtl/dmem_byte_ram.sv
// dmem_byte_ram: single-port 2^DEPTH_LOG2 x 32 RAM with per-byte write enables and registered read.
module dmem_byte_ram #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic                  rd_en,
  input  logic [3:0]            we,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);
  logic [31:0] mem [2**DEPTH_LOG2];
  always_ff @(posedge clk) begin
    if (rd_en) rdata <= mem[addr];
    for (int i = 0; i < 4; i++)
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated responder for the core d_* port over a byte-lane RAM.
// Defining DMEM_RESP_MMIO_EN adds the console (mmio_valid/mmio_data) and sticky halt registers.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
  parameter int          RD_WAIT    = 0,
  parameter int          WR_WAIT    = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d_addr,
  input  logic        d_rd_req,
  output logic        d_rd_ready,
  output logic [31:0] d_rd_data,
  input  logic        d_wr_req,
  output logic        d_wr_ready,
  input  logic [3:0]  d_wr_be,
  input  logic [31:0] d_wr_data,
  output logic        err_oor
`ifdef DMEM_RESP_MMIO_EN
  ,
  output logic        mmio_valid,
  output logic [31:0] mmio_data,
  output logic        halt
`endif
);
  state_t      state;
  wait_t       cnt;
  logic [29:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] data_q, ram_q;
  logic        in_ram, is_con, is_halt, ok, commit, unused_lo;
  assign unused_lo = ^d_addr[1:0];
  // Ready strobes decode straight from state so reset drops them asynchronously;
  // write ready also needs the request still present, so a late abort shows no pulse.
  always_comb begin
    in_ram = addr_q[29:DEPTH_LOG2] == BASE_ADDR[31:DEPTH_LOG2+2];
`ifdef DMEM_RESP_MMIO_EN
    is_con = addr_q == MMIO_CONSOLE_ADDR[31:2];
    is_halt = addr_q == MMIO_HALT_ADDR[31:2];
`else
    is_con = 1'b0;
    is_halt = 1'b0;
`endif
    ok = in_ram | is_con | is_halt;
    commit = state == ST_WR_RESP && d_wr_req;
    d_rd_ready = state == ST_RD_RESP;
    d_wr_ready = commit;
    d_rd_data = d_rd_ready && in_ram ? ram_q : '0;
  end
  dmem_byte_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk   (clk),
    .addr  (addr_q[DEPTH_LOG2-1:0]),
    .rd_en (state == ST_RD_WAIT && cnt == '0),
    .we    ({4{commit & in_ram}} & be_q),
    .wdata (data_q),
    .rdata (ram_q)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt <= '0;
      addr_q <= '0;
      be_q <= '0;
      data_q <= '0;
      err_oor <= 1'b0;
`ifdef DMEM_RESP_MMIO_EN
      mmio_valid <= 1'b0;
      mmio_data <= '0;
      halt <= 1'b0;
`endif
    end else begin
      err_oor <= err_oor | ((d_rd_ready | d_wr_ready) & ~ok);
`ifdef DMEM_RESP_MMIO_EN
      mmio_valid <= commit & is_con;
      if (commit && is_con) mmio_data <= data_q;
      halt <= halt | (commit & is_halt);
`endif
      case (state)
        ST_IDLE:
          if (d_rd_req) begin
            state <= ST_RD_WAIT;
            cnt <= 4'(RD_WAIT);
            addr_q <= d_addr[31:2];
          end else if (d_wr_req) begin
            state <= ST_WR_WAIT;
            cnt <= 4'(WR_WAIT);
            addr_q <= d_addr[31:2];
            be_q <= d_wr_be;
            data_q <= d_wr_data;
          end
        ST_RD_WAIT:
          if (cnt == '0) state <= ST_RD_RESP;
          else cnt <= cnt - 4'd1;
        ST_WR_WAIT:
          if (!d_wr_req) state <= ST_IDLE;
          else if (cnt == '0) state <= ST_WR_RESP;
          else cnt <= cnt - 4'd1;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: two responders (no wait states / RD 3, WR 2) checked against a word-array model.
module tb_dmem_responder;
  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam int DL = 12;
  localparam int RW1 = 3;
  localparam int WW1 = 2;
`ifdef DMEM_RESP_MMIO_EN
  localparam bit MMIO_ON = 1'b1;
`else
  localparam bit MMIO_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  logic [31:0] addr[2], wdata[2], rdata[2];
  logic [3:0] be[2];
  logic rd_req[2], wr_req[2], rd_rdy[2], wr_rdy[2], err[2];
`ifdef DMEM_RESP_MMIO_EN
  logic mv[2], hlt[2];
  logic [31:0] md[2];
`endif
  int checks = 0;
  int errors = 0;
  logic [31:0] mdl[2][16];
  logic err_m[2];
  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_LOG2(DL), .BASE_ADDR(BASE), .RD_WAIT(0), .WR_WAIT(0)) u0 (
    .clk(clk), .rst(rst), .d_addr(addr[0]), .d_rd_req(rd_req[0]), .d_rd_ready(rd_rdy[0]),
    .d_rd_data(rdata[0]), .d_wr_req(wr_req[0]), .d_wr_ready(wr_rdy[0]), .d_wr_be(be[0]),
    .d_wr_data(wdata[0]), .err_oor(err[0])
`ifdef DMEM_RESP_MMIO_EN
    , .mmio_valid(mv[0]), .mmio_data(md[0]), .halt(hlt[0])
`endif
  );
  dmem_responder #(.DEPTH_LOG2(DL), .BASE_ADDR(BASE), .RD_WAIT(RW1), .WR_WAIT(WW1)) u1 (
    .clk(clk), .rst(rst), .d_addr(addr[1]), .d_rd_req(rd_req[1]), .d_rd_ready(rd_rdy[1]),
    .d_rd_data(rdata[1]), .d_wr_req(wr_req[1]), .d_wr_ready(wr_rdy[1]), .d_wr_be(be[1]),
    .d_wr_data(wdata[1]), .err_oor(err[1])
`ifdef DMEM_RESP_MMIO_EN
    , .mmio_valid(mv[1]), .mmio_data(md[1]), .halt(hlt[1])
`endif
  );

  function automatic int rlat(input int k);
    return 1 + (k == 1 ? RW1 : 0);
  endfunction
  function automatic int wlat(input int k);
    return 1 + (k == 1 ? WW1 : 0);
  endfunction
  function automatic bit in_ram(input logic [31:0] a);
    return a >= BASE && a < BASE + 32'(4 << DL);
  endfunction
  function automatic bit is_mmio(input logic [31:0] a);
    return MMIO_ON && (a == 32'hFFFF_FFF0 || a == 32'hFFFF_FFF4);
  endfunction

  task automatic mwrite(input int k, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    int w;
    w = int'((a - BASE) >> 2);
    if (in_ram(a)) begin
      for (int i = 0; i < 4; i++) if (b[i]) mdl[k][w][8*i +: 8] = d[8*i +: 8];
    end else if (!is_mmio(a)) err_m[k] = 1'b1;
  endtask
  task automatic mread(input int k, input logic [31:0] a, output logic [31:0] d);
    d = in_ram(a) ? mdl[k][int'((a - BASE) >> 2)] : 32'h0;
    if (!in_ram(a) && !is_mmio(a)) err_m[k] = 1'b1;
  endtask

  task automatic rd(input int k, input logic [31:0] a, output logic [31:0] d, output int lat);
    @(negedge clk);
    addr[k] = a;
    rd_req[k] = 1'b1;
    @(posedge clk);
    lat = 0;
    d = '0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(posedge clk);
      #1;
      if (rd_rdy[k]) begin
        lat = i;
        d = rdata[k];
      end
    end
    if (lat != 0) begin
      @(posedge clk);
      #1;
    end
    rd_req[k] = 1'b0;
  endtask

  task automatic wr(input int k, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d,
                    input int drop, output int lat);
    @(negedge clk);
    addr[k] = a;
    be[k] = b;
    wdata[k] = d;
    wr_req[k] = 1'b1;
    @(posedge clk);
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(posedge clk);
      #1;
      if (i == drop) begin
        wr_req[k] = 1'b0;
        #1;
      end
      if (wr_rdy[k]) lat = i;
    end
    if (lat != 0) begin
      @(posedge clk);
      #1;
    end
    wr_req[k] = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      checks += 4;
      if (rd_rdy[k] !== 1'b0) begin errors++; $display("FAIL reset_rd_ready k=%0d got %b exp 0", k, rd_rdy[k]); end
      if (wr_rdy[k] !== 1'b0) begin errors++; $display("FAIL reset_wr_ready k=%0d got %b exp 0", k, wr_rdy[k]); end
      if (rdata[k] !== 32'h0) begin errors++; $display("FAIL reset_rd_data k=%0d got %h exp 0", k, rdata[k]); end
      if (err[k] !== 1'b0) begin errors++; $display("FAIL reset_err k=%0d got %b exp 0", k, err[k]); end
`ifdef DMEM_RESP_MMIO_EN
      checks++;
      if ({mv[k], hlt[k], md[k]} !== 34'h0) begin errors++; $display("FAIL reset_mmio k=%0d got %b %b %h exp 0", k, mv[k], hlt[k], md[k]); end
`endif
    end
  endtask

  task automatic test_fill();
    int lat;
    logic [31:0] d;
    for (int k = 0; k < 2; k++)
      for (int w = 0; w < 16; w++) begin
        d = $urandom;
        wr(k, BASE + 32'(4 * w), 4'hF, d, 0, lat);
        mwrite(k, BASE + 32'(4 * w), 4'hF, d);
        checks++;
        if (lat != wlat(k)) begin errors++; $display("FAIL fill_lat k=%0d w=%0d got %0d exp %0d", k, w, lat, wlat(k)); end
      end
  endtask

  task automatic test_lanes();
    int lat;
    logic [31:0] q;
    logic [3:0] bes[4] = '{4'hF, 4'h2, 4'hC, 4'h0};
    logic [31:0] ds[4] = '{32'hDEADBEEF, 32'h0000AA00, 32'h12340000, 32'hFFFFFFFF};
    logic [31:0] ex[4] = '{32'hDEADBEEF, 32'hDEADAAEF, 32'h1234AAEF, 32'h1234AAEF};
    for (int i = 0; i < 4; i++) begin
      wr(0, 32'h0001_0010, bes[i], ds[i], 0, lat);
      mwrite(0, 32'h0001_0010, bes[i], ds[i]);
      checks++;
      if (lat != 1) begin errors++; $display("FAIL lanes_wr_lat i=%0d got %0d exp 1", i, lat); end
      rd(0, 32'h0001_0010, q, lat);
      checks += 3;
      if (lat != 1) begin errors++; $display("FAIL lanes_rd_lat i=%0d got %0d exp 1", i, lat); end
      if (q !== ex[i]) begin errors++; $display("FAIL lanes_data i=%0d got %h exp %h", i, q, ex[i]); end
      if (rd_rdy[0] !== 1'b0) begin errors++; $display("FAIL lanes_rd_width i=%0d got %b exp 0", i, rd_rdy[0]); end
    end
  endtask

  task automatic test_latency();
    int lat;
    logic [31:0] q, e, d;
    d = $urandom;
    wr(1, BASE + 32'h1C, 4'hF, d, 0, lat);
    mwrite(1, BASE + 32'h1C, 4'hF, d);
    checks += 2;
    if (lat != 3) begin errors++; $display("FAIL lat_wr got %0d exp 3", lat); end
    if (wr_rdy[1] !== 1'b0) begin errors++; $display("FAIL lat_wr_width got %b exp 0", wr_rdy[1]); end
    rd(1, BASE + 32'h1C, q, lat);
    mread(1, BASE + 32'h1C, e);
    checks += 3;
    if (lat != 4) begin errors++; $display("FAIL lat_rd got %0d exp 4", lat); end
    if (q !== e) begin errors++; $display("FAIL lat_rd_data got %h exp %h", q, e); end
    if (rd_rdy[1] !== 1'b0) begin errors++; $display("FAIL lat_rd_width got %b exp 0", rd_rdy[1]); end
  endtask

  task automatic test_abort();
    int lat;
    int drops[2] = '{1, 3};
    logic [31:0] q, e;
    for (int i = 0; i < 2; i++) begin
      wr(1, BASE + 32'h20, 4'hF, ~mdl[1][8], drops[i], lat);
      checks++;
      if (lat != 0) begin errors++; $display("FAIL abort_ready drop=%0d got lat %0d exp none", drops[i], lat); end
      rd(1, BASE + 32'h20, q, lat);
      mread(1, BASE + 32'h20, e);
      checks += 2;
      if (lat != 4) begin errors++; $display("FAIL abort_idle drop=%0d got lat %0d exp 4", drops[i], lat); end
      if (q !== e) begin errors++; $display("FAIL abort_data drop=%0d got %h exp %h", drops[i], q, e); end
    end
  endtask

  task automatic test_oor();
    int lat;
    logic [31:0] q;
    checks++;
    if (err[0] !== 1'b0) begin errors++; $display("FAIL oor_pre got %b exp 0", err[0]); end
    rd(0, 32'h0000_0100, q, lat);
    checks += 3;
    if (lat != 1) begin errors++; $display("FAIL oor_rd_lat got %0d exp 1", lat); end
    if (q !== 32'h0) begin errors++; $display("FAIL oor_rd_data got %h exp 0", q); end
    if (err[0] !== 1'b1) begin errors++; $display("FAIL oor_err got %b exp 1", err[0]); end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (err[0] !== 1'b1) begin errors++; $display("FAIL oor_sticky got %b exp 1", err[0]); end
    wr(1, BASE + 32'h4000, 4'hF, 32'h5555_AAAA, 0, lat);
    checks += 2;
    if (lat != 3) begin errors++; $display("FAIL oor_wr_lat got %0d exp 3", lat); end
    if (err[1] !== 1'b1) begin errors++; $display("FAIL oor_wr_err got %b exp 1", err[1]); end
  endtask

  task automatic test_rst_mid();
    int lat;
    bit seen;
    logic [31:0] q, e;
    @(negedge clk);
    addr[1] = BASE + 32'h24;
    be[1] = 4'hF;
    wdata[1] = ~mdl[1][9];
    wr_req[1] = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = wr_rdy[1];
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rst_mid_ready got none exp pulse"); end
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({rd_rdy[k], wr_rdy[k], err[k], rdata[k]} !== 35'h0)
        begin errors++; $display("FAIL rst_mid_outputs k=%0d got %b%b%b %h exp 0", k, rd_rdy[k], wr_rdy[k], err[k], rdata[k]); end
    end
    @(negedge clk);
    rst = 1'b0;
    wr_req[1] = 1'b0;
    err_m[0] = 1'b0;
    err_m[1] = 1'b0;
    rd(1, BASE + 32'h24, q, lat);
    mread(1, BASE + 32'h24, e);
    checks += 2;
    if (lat != 4) begin errors++; $display("FAIL rst_mid_rd_lat got %0d exp 4", lat); end
    if (q !== e) begin errors++; $display("FAIL rst_mid_no_write got %h exp %h", q, e); end
  endtask

  task automatic test_mmio();
    int lat;
    logic [31:0] q;
`ifdef DMEM_RESP_MMIO_EN
    wr(0, 32'hFFFF_FFF0, 4'hF, 32'h41, 0, lat);
    checks += 3;
    if (lat != 1) begin errors++; $display("FAIL mmio_con_lat got %0d exp 1", lat); end
    if (mv[0] !== 1'b1) begin errors++; $display("FAIL mmio_valid got %b exp 1", mv[0]); end
    if (md[0] !== 32'h41) begin errors++; $display("FAIL mmio_data got %h exp 41", md[0]); end
    @(posedge clk);
    #1;
    checks += 2;
    if (mv[0] !== 1'b0) begin errors++; $display("FAIL mmio_valid_width got %b exp 0", mv[0]); end
    if (hlt[0] !== 1'b0) begin errors++; $display("FAIL mmio_halt_pre got %b exp 0", hlt[0]); end
    wr(0, 32'hFFFF_FFF4, 4'hF, 32'h1, 0, lat);
    checks += 2;
    if (hlt[0] !== 1'b1) begin errors++; $display("FAIL mmio_halt got %b exp 1", hlt[0]); end
    if (err[0] !== 1'b0) begin errors++; $display("FAIL mmio_halt_err got %b exp 0", err[0]); end
    rd(0, 32'hFFFF_FFF0, q, lat);
    checks += 2;
    if (q !== 32'h0) begin errors++; $display("FAIL mmio_rd_data got %h exp 0", q); end
    if (err[0] !== 1'b0) begin errors++; $display("FAIL mmio_rd_err got %b exp 0", err[0]); end
`else
    rd(0, 32'hFFFF_FFF0, q, lat);
    err_m[0] = 1'b1;
    checks += 2;
    if (q !== 32'h0) begin errors++; $display("FAIL mmio_off_data got %h exp 0", q); end
    if (err[0] !== 1'b1) begin errors++; $display("FAIL mmio_off_err got %b exp 1", err[0]); end
`endif
  endtask

  task automatic test_random();
    int k, lat;
    logic [31:0] a, d, q, e;
    logic [3:0] b;
    logic [31:0] oor[4] = '{32'h0000_0100, BASE - 32'h4, BASE + 32'h4000, 32'h8000_0000};
    for (int n = 0; n < 60; n++) begin
      k = int'($urandom_range(1, 0));
      a = ($urandom_range(7, 0) == 0) ? oor[$urandom_range(3, 0)] : BASE + 32'(4 * $urandom_range(15, 0));
      if ($urandom_range(1, 0) == 1) begin
        b = 4'($urandom);
        d = $urandom;
        wr(k, a, b, d, 0, lat);
        mwrite(k, a, b, d);
        checks++;
        if (lat != wlat(k)) begin errors++; $display("FAIL rand_wr_lat n=%0d got %0d exp %0d", n, lat, wlat(k)); end
      end else begin
        rd(k, a, q, lat);
        mread(k, a, e);
        checks += 2;
        if (lat != rlat(k)) begin errors++; $display("FAIL rand_rd_lat n=%0d got %0d exp %0d", n, lat, rlat(k)); end
        if (q !== e) begin errors++; $display("FAIL rand_rd_data n=%0d a=%h got %h exp %h", n, a, q, e); end
      end
      checks++;
      if (err[k] !== err_m[k]) begin errors++; $display("FAIL rand_err n=%0d k=%0d got %b exp %b", n, k, err[k], err_m[k]); end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      addr[k] = '0;
      wdata[k] = '0;
      be[k] = '0;
      rd_req[k] = 1'b0;
      wr_req[k] = 1'b0;
      err_m[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_fill();
    test_lanes();
    test_latency();
    test_abort();
    test_oor();
    test_rst_mid();
    test_mmio();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
